// File: rtl/ag_seq_ctrl.sv
// ag_seq_ctrl: multi-pass sequencer for the cyclic address generator
// start/done handshake. It accepts a pass count, runs one start/done
// handshake per pass, and checks the write-enable count of every pass.
//
// Optional feature macro: AG_TIMEOUT_EN
//   defined   -> per-pass watchdog of TMO_CYC cycles; on expiry err is set
//                and the remaining passes are abandoned.
//   undefined -> no watchdog; RUN waits for ag_done indefinitely.
//
// Clock domain: sys_clk only. Reset: reset_n, asynchronous, active low.

module ag_seq_ctrl #(
    parameter int unsigned FEATURE_BITS = 4,
    parameter int unsigned LIM          = 4'b1001,
    parameter int unsigned PASS_BITS    = 4,
    parameter int unsigned TMO_CYC      = 64
) (
    input  logic                 sys_clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [PASS_BITS-1:0] cmd_passes,
    output logic                 ag_start,
    input  logic                 ag_done,
    input  logic                 ag_enable_write,
    output logic                 busy,
    output logic [PASS_BITS-1:0] pass_idx,
    output logic                 seq_done,
    output logic                 err
);

    // One extra bit lets the counter saturate above LIM so an overrun
    // can never wrap back onto the expected value.
    localparam int unsigned      WCNT_W  = FEATURE_BITS + 1;
    localparam logic [WCNT_W-1:0] LIM_CNT = WCNT_W'(LIM);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_GAP    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                state;
    logic [PASS_BITS-1:0]  passes_q;
    logic [WCNT_W-1:0]     wcnt;
    logic [WCNT_W-1:0]     wcnt_next;
    logic                  last_pass;

`ifdef AG_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_CYC);
    logic [TMO_W-1:0] tmo_cnt;
`endif

    // A zero watchdog limit is meaningless; reject it at elaboration.
    if (TMO_CYC == 0) begin : g_tmo_chk
        $error("ag_seq_ctrl: TMO_CYC must be nonzero");
    end

    // Handshake-facing status decodes straight off the state register.
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    // Write count including a write in the current cycle, so a write that
    // coincides with ag_done is still counted for this pass.
    always_comb begin
        wcnt_next = wcnt;
        if (ag_enable_write && (wcnt != '1)) begin
            wcnt_next = wcnt + WCNT_W'(1);
        end
    end

    // pass_idx is 0-based, so the last pass is passes-1.
    assign last_pass = (pass_idx == (passes_q - PASS_BITS'(1)));

    // Sequencer FSM with registered start/index/done/error outputs.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            ag_start <= 1'b0;
            pass_idx <= '0;
            seq_done <= 1'b0;
            err      <= 1'b0;
            wcnt     <= '0;
            passes_q <= '0;
`ifdef AG_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
        end else begin
            seq_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        passes_q <= cmd_passes;
                        err      <= 1'b0;
                        pass_idx <= '0;
                        wcnt     <= '0;
`ifdef AG_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                        if (cmd_passes == '0) begin
                            state    <= S_FINISH;
                            seq_done <= 1'b1;
                        end else begin
                            state    <= S_RUN;
                            ag_start <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    wcnt <= wcnt_next;
                    if (ag_done) begin
                        ag_start <= 1'b0;
                        if (wcnt_next != LIM_CNT) begin
                            err <= 1'b1;
                        end
                        if (last_pass) begin
                            state    <= S_FINISH;
                            seq_done <= 1'b1;
                        end else begin
                            pass_idx <= pass_idx + PASS_BITS'(1);
                            state    <= S_GAP;
                        end
                    end
`ifdef AG_TIMEOUT_EN
                    // ag_done takes priority over an expiry in the same cycle.
                    else if (tmo_cnt == TMO_LIM) begin
                        ag_start <= 1'b0;
                        err      <= 1'b1;
                        state    <= S_FINISH;
                        seq_done <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end

                S_GAP: begin
                    // Start is low here for at least one cycle so the
                    // generator resets its addresses before re-arming.
                    wcnt <= '0;
                    if (!ag_done) begin
                        state    <= S_RUN;
                        ag_start <= 1'b1;
`ifdef AG_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                    end
                end

                S_FINISH: begin
                    state <= S_IDLE;
                end

                default: begin
                    state    <= S_IDLE;
                    ag_start <= 1'b0;
                end
            endcase
        end
    end

endmodule
